// File: rtl/spi_master.sv
// spi_master: SPI initiator for all four CPOL/CPHA modes. It sends and receives one word per ss assertion.
// Build option SPI_MASTER_LOOPBACK_EN adds a loopback input; when set, the sample path reads mosi instead of miso.
module spi_master #(
   parameter int clk_polarity = 0,
   parameter int clk_phase    = 0,
   parameter int DATA_WIDTH   = 16,
   parameter int CLK_DIV      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy,
   output logic                  sclk,
   output logic                  mosi,
   input  logic                  miso,
`ifdef SPI_MASTER_LOOPBACK_EN
   input  logic                  loopback,
`endif
   output logic                  ss
);
   localparam logic CPOL = (clk_polarity != 0);
   localparam logic CPHA = (clk_phase != 0);
   localparam int   DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int   EW   = $clog2(2 * DATA_WIDTH);
   localparam logic [DIVW-1:0] LAST_DIV  = DIVW'(CLK_DIV - 1);
   localparam logic [EW-1:0]   LAST_EDGE = EW'(2 * DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

   state_t                state_q, state_d;
   logic [DIVW-1:0]       div_cnt_q, div_cnt_d;
   logic [EW-1:0]         edge_cnt_q, edge_cnt_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  sclk_q, sclk_d;
   logic                  ss_q, ss_d;
   logic                  mosi_q, mosi_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  tick, accept, last_edge, sample_edge, drive_edge, sample_bit;
`ifdef SPI_MASTER_LOOPBACK_EN
   logic                  loopback_q, loopback_d;
`endif

   assign tick      = (state_q != IDLE) && (div_cnt_q == LAST_DIV);
   assign accept    = (state_q == IDLE) && tx_valid;
   assign last_edge = (edge_cnt_q == LAST_EDGE);

   // CPHA=0 samples on even edges and drives on odd ones; CPHA=1 swaps the parity.
   assign sample_edge = (state_q == XFER) && tick && (edge_cnt_q[0] == CPHA);
   assign drive_edge  = (state_q == XFER) && tick && (edge_cnt_q[0] != CPHA) && !last_edge;

`ifdef SPI_MASTER_LOOPBACK_EN
   assign sample_bit = loopback_q ? mosi_q : miso;
`else
   assign sample_bit = miso;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         div_cnt_q  <= '0;
         edge_cnt_q <= '0;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         sclk_q     <= CPOL;
         ss_q       <= 1'b1;
         mosi_q     <= 1'b0;
         rx_valid_q <= 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
         loopback_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         div_cnt_q  <= div_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         sclk_q     <= sclk_d;
         ss_q       <= ss_d;
         mosi_q     <= mosi_d;
         rx_valid_q <= rx_valid_d;
`ifdef SPI_MASTER_LOOPBACK_EN
         loopback_q <= loopback_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (tx_valid)            state_d = SETUP;
         SETUP:   if (tick)                state_d = XFER;
         XFER:    if (tick && last_edge)   state_d = HOLD;
         HOLD:    if (tick)                state_d = GAP;
         GAP:     if (tick)                state_d = IDLE;
         default:                          state_d = IDLE;
      endcase
   end

   always_comb begin
      div_cnt_d  = '0;
      edge_cnt_d = '0;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      sclk_d     = sclk_q;
      ss_d       = ss_q;
      mosi_d     = mosi_q;
      rx_valid_d = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
      loopback_d = loopback_q;
`endif
      if (state_q != IDLE) begin
         div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      end
      if (state_q == XFER) begin
         edge_cnt_d = edge_cnt_q;
         if (tick) begin
            edge_cnt_d = last_edge ? '0 : edge_cnt_q + 1'b1;
            sclk_d     = ~sclk_q;
         end
      end
      if (accept) begin
         ss_d = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
         loopback_d = loopback;
`endif
         // CPHA=0 must present the MSB before the first (sampling) edge.
         if (CPHA) begin
            tx_shift_d = tx_data;
         end else begin
            mosi_d     = tx_data[DATA_WIDTH-1];
            tx_shift_d = tx_data << 1;
         end
      end
      if (drive_edge) begin
         mosi_d     = tx_shift_q[DATA_WIDTH-1];
         tx_shift_d = tx_shift_q << 1;
      end
      if (sample_edge) begin
         rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], sample_bit};
      end
      if ((state_q == HOLD) && tick) begin
         ss_d       = 1'b1;
         rx_data_d  = rx_shift_q;
         rx_valid_d = 1'b1;
      end
   end

   always_comb begin
      tx_ready = (state_q == IDLE);
      busy     = (state_q != IDLE);
      sclk     = sclk_q;
      ss       = ss_q;
      mosi     = mosi_q;
      rx_data  = rx_data_q;
      rx_valid = rx_valid_q;
   end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: runs four spi_master instances, one per SPI mode, in lockstep from shared random stimulus.
// A cycle-offset timing model and a per-mode SPI slave model check every output on every cycle.
module tb_spi_master;
   localparam int DW      = 16;
   localparam int CDIV    = 2;
   localparam int SS_LOW  = CDIV * (2 * DW + 2);
   localparam int RXN     = SS_LOW + 1;
   localparam int TOTAL   = CDIV * (2 * DW + 3);

   logic                clk;
   logic                rst;
   logic                tx_valid;
   logic [DW-1:0]       tx_data;
   logic [DW-1:0]       slave_word;
`ifdef SPI_MASTER_LOOPBACK_EN
   logic                loopback;
`endif

   logic [3:0]          tx_ready_v, rx_valid_v, busy_v, sclk_v, mosi_v, miso_v, ss_v;
   logic [3:0][DW-1:0]  rx_data_v, got_v;

   int nvec = 0;
   int nerr = 0;

   // Expected-behaviour state: where the current transfer is, counted in cycles since accept.
   bit            m_active;
   int            m_n;
   logic [DW-1:0] m_w, m_s, m_rx_hold;
   bit            m_lb;
   logic [3:0]    m_mosi_base;

   int   ss_low_cnt, rise_cnt, rxv_cnt, gap_run, last_gap;
   logic sclk_prev0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar m = 0; m < 4; m++) begin : g_mode
      localparam bit CPOL = (m / 2) == 1;
      localparam bit CPHA = (m % 2) == 1;
      logic          miso_r = 1'b0;
      logic [DW-1:0] out_sh = '0;
      logic [DW-1:0] in_sh  = '0;
      logic [DW-1:0] got_r  = '0;

      spi_master #(
         .clk_polarity(m / 2), .clk_phase(m % 2), .DATA_WIDTH(DW), .CLK_DIV(CDIV)
      ) u_dut (
         .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
         .tx_ready(tx_ready_v[m]), .rx_data(rx_data_v[m]), .rx_valid(rx_valid_v[m]),
         .busy(busy_v[m]), .sclk(sclk_v[m]), .mosi(mosi_v[m]), .miso(miso_v[m]),
`ifdef SPI_MASTER_LOOPBACK_EN
         .loopback(loopback),
`endif
         .ss(ss_v[m])
      );

      assign miso_v[m] = miso_r;
      assign got_v[m]  = got_r;

      // SPI slave: loads slave_word on select, samples/drives on the edges its mode dictates.
      initial begin
         bit ss_prev, sclk_prev;
         ss_prev   = 1'b1;
         sclk_prev = CPOL;
         forever begin
            @(ss_v[m] or sclk_v[m]);
            if (ss_v[m] !== ss_prev) begin
               if (ss_v[m] == 1'b0) begin
                  out_sh = slave_word;
                  in_sh  = '0;
                  if (!CPHA) miso_r = out_sh[DW-1];
               end else begin
                  got_r  = in_sh;
                  miso_r = 1'($urandom);
               end
            end else if (ss_v[m] == 1'b0 && sclk_v[m] !== sclk_prev) begin
               if ((sclk_v[m] != CPOL) != CPHA) begin
                  in_sh = {in_sh[DW-2:0], mosi_v[m]};
               end else if (CPHA) begin
                  miso_r = out_sh[DW-1];
                  out_sh = out_sh << 1;
               end else begin
                  out_sh = out_sh << 1;
                  miso_r = out_sh[DW-1];
               end
            end
            ss_prev   = ss_v[m];
            sclk_prev = sclk_v[m];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Number of sclk toggles already visible n cycles after accept.
   function automatic int toggles(input int n);
      int t;
      t = (n - 1) / CDIV - 1;
      if (t < 0) t = 0;
      if (t > 2 * DW) t = 2 * DW;
      return t;
   endfunction

   task automatic checkOutput();
      int            t, d;
      bit            ss_e, rxv_e, cpol, cpha;
      logic          mosi_e;
      logic [DW-1:0] rx_e;
      ss_e  = !(m_active && m_n <= SS_LOW);
      rxv_e = m_active && (m_n == RXN);
      rx_e  = (m_active && m_n >= RXN) ? (m_lb ? m_w : m_s) : m_rx_hold;
      t     = m_active ? toggles(m_n) : 0;
      for (int m = 0; m < 4; m++) begin
         cpol = (m / 2) == 1;
         cpha = (m % 2) == 1;
         if (!m_active) begin
            mosi_e = m_mosi_base[m];
         end else if (!cpha) begin
            d = 1 + ((t / 2 < DW - 1) ? t / 2 : DW - 1);
            mosi_e = m_w[DW-d];
         end else begin
            d = (t + 1) / 2;
            mosi_e = (d == 0) ? m_mosi_base[m] : m_w[DW-d];
         end
         chk($sformatf("ss[m%0d]", m), 32'(ss_v[m]), 32'(ss_e));
         chk($sformatf("sclk[m%0d]", m), 32'(sclk_v[m]), 32'(cpol ^ t[0]));
         chk($sformatf("mosi[m%0d]", m), 32'(mosi_v[m]), 32'(mosi_e));
         chk($sformatf("busy[m%0d]", m), 32'(busy_v[m]), 32'(m_active));
         chk($sformatf("tx_ready[m%0d]", m), 32'(tx_ready_v[m]), 32'(!m_active));
         chk($sformatf("rx_valid[m%0d]", m), 32'(rx_valid_v[m]), 32'(rxv_e));
         chk($sformatf("rx_data[m%0d]", m), 32'(rx_data_v[m]), 32'(rx_e));
         if (rxv_e) chk($sformatf("slave_rx[m%0d]", m), 32'(got_v[m]), 32'(m_w));
      end
      if (ss_v[0] == 1'b0) begin
         ss_low_cnt++;
         if (gap_run > 0) last_gap = gap_run;
         gap_run = 0;
      end else begin
         gap_run++;
      end
      if (sclk_v[0] == 1'b1 && sclk_prev0 == 1'b0) rise_cnt++;
      sclk_prev0 = sclk_v[0];
      if (rx_valid_v[0] == 1'b1) rxv_cnt++;
   endtask

   task automatic advanceModel();
      if (rst) begin
         m_active    = 1'b0;
         m_n         = 0;
         m_rx_hold   = '0;
         m_mosi_base = '0;
      end else if (!m_active) begin
         if (tx_valid) begin
            m_active = 1'b1;
            m_n      = 1;
            m_w      = tx_data;
            m_s      = slave_word;
            m_lb     = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
            m_lb     = loopback;
`endif
         end
      end else begin
         m_n++;
         if (m_n > TOTAL) begin
            m_active    = 1'b0;
            m_rx_hold   = m_lb ? m_w : m_s;
            m_mosi_base = {4{m_w[0]}};
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      checkOutput();
      advanceModel();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input bit valid, input logic [DW-1:0] data, input logic [DW-1:0] sword);
      tx_valid   = valid;
      tx_data    = data;
      slave_word = sword;
   endtask

   task automatic runUntilIdle();
      int i;
      for (i = 0; i < 4 * TOTAL && m_active; i++) cycle();
      chk("idle_bound", 32'(m_active), 32'd0);
   endtask

   initial begin
      int b_ss, b_rise, b_rxv;
      rst = 1'b1; tx_valid = 1'b0; tx_data = '0; slave_word = '0;
`ifdef SPI_MASTER_LOOPBACK_EN
      loopback = 1'b0;
`endif
      m_active = 1'b0; m_n = 0; m_w = '0; m_s = '0; m_rx_hold = '0; m_lb = 1'b0; m_mosi_base = '0;
      ss_low_cnt = 0; rise_cnt = 0; rxv_cnt = 0; gap_run = 0; last_gap = 0; sclk_prev0 = 1'b0;
      @(posedge clk); #1;
      repeat (3) cycle();
      rst = 1'b0;
      cycle();

      // Mode 0 reference transfer.
      b_ss = ss_low_cnt; b_rise = rise_cnt; b_rxv = rxv_cnt;
      applyStimulus(1'b1, 16'hA5C3, 16'h5A5A);
      cycle();
      applyStimulus(1'b0, 16'h0000, 16'h0000);
      runUntilIdle();
      chk("ss_low_cycles", 32'(ss_low_cnt - b_ss), 32'd68);
      chk("sclk_rises_m0", 32'(rise_cnt - b_rise), 32'd16);
      chk("rx_pulses_m0", 32'(rxv_cnt - b_rxv), 32'd1);
      chk("rx_data_m0", 32'(rx_data_v[0]), 32'h5A5A);
      chk("slave_got_m0", 32'(got_v[0]), 32'hA5C3);

      // Mode 3 reference transfer.
      applyStimulus(1'b1, 16'h0001, 16'h8000);
      cycle();
      applyStimulus(1'b0, 16'h0000, 16'h0000);
      runUntilIdle();
      chk("rx_data_m3", 32'(rx_data_v[3]), 32'h8000);
      chk("slave_got_m3", 32'(got_v[3]), 32'h0001);
      chk("sclk_idle_m3", 32'(sclk_v[3]), 32'd1);

      // Back-to-back words with tx_valid held high.
      b_rxv = rxv_cnt;
      applyStimulus(1'b1, 16'h1111, 16'h0F0F);
      cycle();
      applyStimulus(1'b1, 16'h2222, 16'hF00F);
      for (int i = 0; i < 4 * TOTAL && m_active; i++) cycle();
      cycle();
      applyStimulus(1'b0, 16'h0000, 16'h0000);
      runUntilIdle();
      chk("b2b_rx_pulses", 32'(rxv_cnt - b_rxv), 32'd2);
      chk("b2b_gap_ge2", 32'(last_gap >= 2), 32'd1);
      chk("b2b_slave_got", 32'(got_v[1]), 32'h2222);

      // Reset after edge k=10, then a clean transfer.
      b_rxv = rxv_cnt;
      applyStimulus(1'b1, 16'h1234, 16'h4321);
      cycle();
      applyStimulus(1'b0, 16'h0000, 16'h0000);
      for (int i = 0; i < 4 * TOTAL && toggles(m_n) < 11; i++) cycle();
      rst = 1'b1;
      cycle();
      chk("rst_ss", 32'(ss_v), 32'hF);
      chk("rst_sclk", 32'(sclk_v), 32'hC);
      chk("rst_tx_ready", 32'(tx_ready_v), 32'hF);
      rst = 1'b0;
      cycle();
      chk("rst_no_rx_pulse", 32'(rxv_cnt - b_rxv), 32'd0);
      applyStimulus(1'b1, 16'hBEEF, 16'h3C69);
      cycle();
      applyStimulus(1'b0, 16'h0000, 16'h0000);
      runUntilIdle();
      chk("post_rst_slave_got", 32'(got_v[0]), 32'hBEEF);
      chk("post_rst_rx_data", 32'(rx_data_v[2]), 32'h3C69);

      // tx_data changes after accept must not reach the slave.
      applyStimulus(1'b1, 16'h00F0, 16'h1357);
      cycle();
      applyStimulus(1'b0, 16'hFFFF, 16'h0000);
      runUntilIdle();
      chk("held_word_m0", 32'(got_v[0]), 32'h00F0);
      chk("held_word_m3", 32'(got_v[3]), 32'h00F0);

`ifdef SPI_MASTER_LOOPBACK_EN
      loopback = 1'b1;
      applyStimulus(1'b1, 16'hC0DE, 16'h0000);
      cycle();
      loopback = 1'b0;
      applyStimulus(1'b0, 16'h0000, 16'h0000);
      runUntilIdle();
      chk("loopback_rx", 32'(rx_data_v[0]), 32'hC0DE);
`endif

      // Random traffic, including tx_valid during busy and occasional resets.
      for (int i = 0; i < 2500; i++) begin
         rst = ($urandom_range(0, 399) == 0);
         applyStimulus($urandom_range(0, 3) == 0, DW'($urandom), DW'($urandom));
`ifdef SPI_MASTER_LOOPBACK_EN
         loopback = 1'($urandom_range(0, 1));
`endif
         cycle();
      end
      rst = 1'b0;
      applyStimulus(1'b0, 16'h0000, 16'h0000);
      runUntilIdle();
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
